spi_xfer_arbiter: RTL and testbench

//  Shares one SPI_TOP master among NREQ requesters. Round-robin arbitration picks a requester,

---
 rtl/spi_xfer_arbiter_pkg.sv | 38 +++
 rtl/spi_xfer_arbiter_if.sv | 33 +++
 rtl/spi_xfer_arbiter_rr_arbiter.sv | 30 +++
 rtl/spi_xfer_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared definitions for the SPI transfer arbiter: FSM encodings, SPCR bit
// positions and the helper that assembles an SPCR byte from a requester mode.
package spi_xfer_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  localparam int SPE_B   = 6;
  localparam int MSTR_B  = 4;
  localparam int CPOL_B  = 3;
  localparam int CPHA_B  = 2;
  localparam int LSBFE_B = 0;

  localparam logic [7:0] SPCR_RST = 8'h10;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsbfe;
  } spi_mode_t;

  // Master mode is always set; only SPE and the per-requester mode bits vary.
  function automatic logic [7:0] build_spcr(input spi_mode_t m, input logic spe);
    logic [7:0] r;
    r          = 8'h00;
    r[MSTR_B]  = 1'b1;
    r[SPE_B]   = spe;
    r[CPOL_B]  = m.cpol;
    r[CPHA_B]  = m.cpha;
    r[LSBFE_B] = m.lsbfe;
    return r;
  endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Bundle of the client-side request/response bus and the SPI_TOP control
// lines; master is the arbiter, slave is the clients plus SPI_TOP.
interface spi_xfer_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_tx;
  logic [3*NREQ-1:0] req_mode;
  logic [3*NREQ-1:0] req_spr;
  logic [NREQ-1:0]   grant;
  logic              done;
  logic              timeout;
  logic [7:0]        rx_data;
  logic              busy;
  logic [7:0]        spi_spcr;
  logic [7:0]        spi_spibr;
  logic [7:0]        spi_spdr;
  logic              spi_ss_n;
  logic              spi_spif;
  logic [7:0]        spi_rx;

  modport master (
    input  req, req_tx, req_mode, req_spr, spi_spif, spi_rx,
    output grant, done, timeout, rx_data, busy,
           spi_spcr, spi_spibr, spi_spdr, spi_ss_n
  );

  modport slave (
    output req, req_tx, req_mode, req_spr, spi_spif, spi_rx,
    input  grant, done, timeout, rx_data, busy,
           spi_spcr, spi_spibr, spi_spdr, spi_ss_n
  );
endinterface

// File: rtl/spi_xfer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI_TOP master among NREQ requesters: round-robin grant, program
// SPCR/SPIBR/SPDR, run one byte under SS, return the RX byte, then idle a gap.
module spi_xfer_arbiter
  import spi_xfer_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int SETUP_CYC = 2,
  parameter int GAP_CYC   = 4,
  parameter int TO_CYC    = 4096
) (
  input  logic               clk,
  input  logic               rst,
  spi_xfer_arbiter_if.master bus
);
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int GAP_N   = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int MAX_SG  = (SETUP_N > GAP_N) ? SETUP_N : GAP_N;
  localparam int MAXC    = (MAX_SG > TO_CYC) ? MAX_SG : TO_CYC;
  localparam int CNT_W   = $clog2(MAXC + 1);

  logic [2:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] cnt;
  logic             spif_d;
  logic             to_flag;
  spi_mode_t        mode_q;

  logic [NREQ-1:0]  grant_q;
  logic             done_q;
  logic             timeout_q;
  logic [7:0]       rx_q;
  logic             busy_q;
  logic [7:0]       spcr_q;
  logic [7:0]       spibr_q;
  logic [7:0]       spdr_q;
  logic             ss_n_q;

  logic [NREQ-1:0]  arb_grant;
  logic [IW-1:0]    arb_idx;
  logic [7:0]       sel_tx;
  spi_mode_t        sel_mode;
  logic [2:0]       sel_spr;
  logic             spif_rise;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_tx   = '0;
    sel_mode = '0;
    sel_spr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_tx   = bus.req_tx[i*8 +: 8];
        sel_mode = bus.req_mode[i*3 +: 3];
        sel_spr  = bus.req_spr[i*3 +: 3];
      end
    end
  end

  // A level already high when WAIT begins must not complete the transfer.
  assign spif_rise = bus.spi_spif & ~spif_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      idx       <= '0;
      cnt       <= '0;
      spif_d    <= 1'b0;
      to_flag   <= 1'b0;
      mode_q    <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rx_q      <= 8'h00;
      busy_q    <= 1'b0;
      spcr_q    <= SPCR_RST;
      spibr_q   <= 8'h00;
      spdr_q    <= 8'h00;
      ss_n_q    <= 1'b1;
    end else begin
      spif_d    <= bus.spi_spif;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            idx     <= arb_idx;
            grant_q <= arb_grant;
            mode_q  <= sel_mode;
            spcr_q  <= build_spcr(sel_mode, 1'b0);
            spibr_q <= {5'b00000, sel_spr};
            spdr_q  <= sel_tx;
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt     <= '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == CNT_W'(SETUP_N - 1)) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          spcr_q  <= build_spcr(mode_q, 1'b1);
          cnt     <= '0;
          to_flag <= 1'b0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spif_rise) begin
            state <= ST_FINISH;
          end else if (TO_CYC != 0 && cnt == CNT_W'(TO_CYC - 1)) begin
            to_flag <= 1'b1;
            state   <= ST_FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          if (!to_flag) rx_q <= bus.spi_rx;
          done_q    <= 1'b1;
          timeout_q <= to_flag;
          spcr_q    <= build_spcr(mode_q, 1'b0);
          ss_n_q    <= 1'b1;
          grant_q   <= '0;
          ptr       <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          cnt       <= '0;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_N - 1)) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.rx_data   = rx_q;
  assign bus.busy      = busy_q;
  assign bus.spi_spcr  = spcr_q;
  assign bus.spi_spibr = spibr_q;
  assign bus.spi_spdr  = spdr_q;
  assign bus.spi_ss_n  = ss_n_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: the bench plays both the clients and
// SPI_TOP, raising SPIF by hand and checking every response against constants.
module tb_spi_xfer_arbiter;
  localparam int NREQ   = 4;
  localparam int SETUP  = 2;
  localparam int GAP    = 4;
  localparam int TO     = 64;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;
  int   gap_run;
  int   last_gap;

  spi_xfer_arbiter_if #(.NREQ(NREQ)) bus ();

  spi_xfer_arbiter #(
    .NREQ(NREQ), .SETUP_CYC(SETUP), .GAP_CYC(GAP), .TO_CYC(TO)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Length of the most recent completed run of ss_n-high cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      gap_run = 0;
    end else if (bus.spi_ss_n) begin
      gap_run = gap_run + 1;
    end else if (gap_run != 0) begin
      last_gap = gap_run;
      gap_run  = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin step(); n++; end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic wait_spe(input string tag);
    int n;
    n = 0;
    while (!bus.spi_spcr[6] && n < 50) begin step(); n++; end
    chk(tag, {31'd0, bus.spi_spcr[6]}, 32'd1);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin step(); n++; end while (!bus.done && n < 200);
    chk(tag, {31'd0, bus.done}, 32'd1);
  endtask

  // One complete transfer with req held; SPIF rises dly cycles into WAIT.
  task automatic xfer(input string tag, input logic [3:0] exp_g, input logic [7:0] rx, input int dly);
    int n;
    n = 0;
    while (bus.spi_ss_n && n < 200) begin step(); n++; end
    chk({tag, "_ss_low"}, {31'd0, bus.spi_ss_n}, 32'd0);
    chk({tag, "_grant"}, {28'd0, bus.grant}, {28'd0, exp_g});
    wait_spe({tag, "_spe"});
    repeat (dly) step();
    bus.spi_rx   = rx;
    bus.spi_spif = 1'b1;
    wait_done({tag, "_done"}, n);
    chk({tag, "_rx"}, {24'd0, bus.rx_data}, {24'd0, rx});
    chk({tag, "_to"}, {31'd0, bus.timeout}, 32'd0);
    bus.spi_spif = 1'b0;
    step();
    chk({tag, "_done_1cyc"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int n;
    int seen_done;
    vec_cnt      = 0;
    err_cnt      = 0;
    gap_run      = 0;
    last_gap     = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_tx   = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req_mode = {3'b111, 3'b100, 3'b001, 3'b010};
    bus.req_spr  = {3'd7, 3'd5, 3'd3, 3'd1};
    bus.spi_spif = 1'b0;
    bus.spi_rx   = 8'h00;
    repeat (3) step();

    // Reset values
    chk("rst_grant",   {28'd0, bus.grant},     32'h0);
    chk("rst_done",    {31'd0, bus.done},      32'h0);
    chk("rst_timeout", {31'd0, bus.timeout},   32'h0);
    chk("rst_rx",      {24'd0, bus.rx_data},   32'h00);
    chk("rst_busy",    {31'd0, bus.busy},      32'h0);
    chk("rst_spcr",    {24'd0, bus.spi_spcr},  32'h10);
    chk("rst_spibr",   {24'd0, bus.spi_spibr}, 32'h00);
    chk("rst_spdr",    {24'd0, bus.spi_spdr},  32'h00);
    chk("rst_ss_n",    {31'd0, bus.spi_ss_n},  32'h1);
    rst_n = 1'b1;
    repeat (2) step();

    // All four requesting: round-robin 0,1,2,3,0 with a full gap between
    bus.req = 4'b1111;
    xfer("rr0", 4'b0001, 8'h81, 5);
    xfer("rr1", 4'b0010, 8'h82, 3);
    chk("rr1_gap", {31'd0, last_gap >= GAP}, 32'd1);
    xfer("rr2", 4'b0100, 8'h83, 7);
    chk("rr2_gap", {31'd0, last_gap >= GAP}, 32'd1);
    xfer("rr3", 4'b1000, 8'h84, 2);
    chk("rr3_gap", {31'd0, last_gap >= GAP}, 32'd1);
    xfer("rr4", 4'b0001, 8'h85, 4);
    chk("rr4_gap", {31'd0, last_gap >= GAP}, 32'd1);
    bus.req = '0;
    wait_idle("rr_idle");

    // Single transfer for requester 0 with hand-computed register images
    bus.req_tx[7:0]   = 8'hA5;
    bus.req_mode[2:0] = 3'b010;
    bus.req_spr[2:0]  = 3'd1;
    bus.req           = 4'b0001;
    step();
    chk("t1_grant", {28'd0, bus.grant},     32'h1);
    chk("t1_spcr0", {24'd0, bus.spi_spcr},  32'h14);
    chk("t1_spibr", {24'd0, bus.spi_spibr}, 32'h01);
    chk("t1_spdr",  {24'd0, bus.spi_spdr},  32'hA5);
    chk("t1_ss_n",  {31'd0, bus.spi_ss_n},  32'h0);
    chk("t1_busy",  {31'd0, bus.busy},      32'h1);
    repeat (2) step();
    chk("t1_spcr_setup", {24'd0, bus.spi_spcr}, 32'h14);
    step();
    chk("t1_spcr_run", {24'd0, bus.spi_spcr}, 32'h54);
    repeat (40) step();
    chk("t1_ss_n_wait", {31'd0, bus.spi_ss_n}, 32'h0);
    bus.spi_rx   = 8'h3C;
    bus.spi_spif = 1'b1;
    step();
    chk("t1_no_done_yet", {31'd0, bus.done}, 32'h0);
    step();
    chk("t1_done",    {31'd0, bus.done},     32'h1);
    chk("t1_rx",      {24'd0, bus.rx_data},  32'h3C);
    chk("t1_ss_hi",   {31'd0, bus.spi_ss_n}, 32'h1);
    chk("t1_grant0",  {28'd0, bus.grant},    32'h0);
    chk("t1_spe_off", {24'd0, bus.spi_spcr}, 32'h14);
    chk("t1_to",      {31'd0, bus.timeout},  32'h0);
    bus.req      = '0;
    bus.spi_spif = 1'b0;
    step();
    chk("t1_done_1cyc", {31'd0, bus.done}, 32'h0);
    wait_idle("t1_idle");

    // No SPIF: abort after TO cycles of WAIT (SPE visible on first WAIT
    // cycle, then TO WAIT cycles and one FINISH cycle before done)
    bus.spi_rx = 8'hEE;
    bus.req    = 4'b0010;
    wait_spe("t3_spe");
    chk("t3_grant", {28'd0, bus.grant}, 32'h2);
    wait_done("t3_done", n);
    chk("t3_latency", n,                     TO + 1);
    chk("t3_timeout", {31'd0, bus.timeout},  32'h1);
    chk("t3_rx_kept", {24'd0, bus.rx_data},  32'h3C);
    bus.req = '0;
    step();
    chk("t3_to_1cyc", {31'd0, bus.timeout}, 32'h0);
    wait_idle("t3_idle");

    // SPIF stuck high before the transfer: only a fresh rising edge completes
    bus.spi_spif = 1'b1;
    bus.req      = 4'b0100;
    wait_spe("t5_spe");
    seen_done = 0;
    repeat (10) begin step(); if (bus.done) seen_done = 1; end
    chk("t5_no_early_done", seen_done, 0);
    bus.spi_spif = 1'b0;
    repeat (3) begin step(); if (bus.done) seen_done = 1; end
    chk("t5_no_done_on_fall", seen_done, 0);
    bus.spi_rx   = 8'h5A;
    bus.spi_spif = 1'b1;
    wait_done("t5_done", n);
    chk("t5_rx", {24'd0, bus.rx_data}, 32'h5A);
    chk("t5_to", {31'd0, bus.timeout}, 32'h0);
    bus.req      = '0;
    bus.spi_spif = 1'b0;
    wait_idle("t5_idle");

    // Requester 2 drops req right after grant (pointer now 3, wraps to 2)
    bus.req = 4'b0100;
    step();
    chk("t6_grant", {28'd0, bus.grant}, 32'h4);
    bus.req = '0;
    wait_spe("t6_spe");
    repeat (5) step();
    bus.spi_rx   = 8'h77;
    bus.spi_spif = 1'b1;
    wait_done("t6_done", n);
    chk("t6_rx",     {24'd0, bus.rx_data}, 32'h77);
    chk("t6_grant0", {28'd0, bus.grant},   32'h0);
    bus.spi_spif = 1'b0;
    wait_idle("t6_idle");
    repeat (3) step();
    chk("t6_stay_idle", {28'd0, bus.grant}, 32'h0);

    // Reset asserted during WAIT: outputs return to reset values at once
    bus.req = 4'b1000;
    wait_spe("t4_spe");
    chk("t4_grant", {28'd0, bus.grant}, 32'h8);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("t4_grant_rst", {28'd0, bus.grant},     32'h0);
    chk("t4_busy_rst",  {31'd0, bus.busy},      32'h0);
    chk("t4_spcr_rst",  {24'd0, bus.spi_spcr},  32'h10);
    chk("t4_spibr_rst", {24'd0, bus.spi_spibr}, 32'h00);
    chk("t4_spdr_rst",  {24'd0, bus.spi_spdr},  32'h00);
    chk("t4_ss_rst",    {31'd0, bus.spi_ss_n},  32'h1);
    chk("t4_rx_rst",    {24'd0, bus.rx_data},   32'h00);
    chk("t4_done_rst",  {31'd0, bus.done},      32'h0);
    bus.req = '0;
    repeat (2) step();
    rst_n = 1'b1;
    seen_done = 0;
    repeat (3) begin step(); if (bus.done) seen_done = 1; end
    chk("t4_no_done", seen_done, 0);
    chk("t4_idle",    {31'd0, bus.busy}, 32'h0);
    // Pointer back at 0: of requesters 1 and 3, requester 1 wins
    bus.req = 4'b1010;
    step();
    chk("t4_ptr_reset", {28'd0, bus.grant}, 32'h2);
    bus.req = '0;
    wait_spe("t4b_spe");
    bus.spi_rx   = 8'h19;
    bus.spi_spif = 1'b1;
    wait_done("t4b_done", n);
    chk("t4b_rx", {24'd0, bus.rx_data}, 32'h19);
    bus.spi_spif = 1'b0;
    wait_idle("t4b_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
